// File: rtl/kd_nn_search.sv
// -----------------------------------------------------------------------------
// kd_nn_search
//   Nearest-centre search over a kd-tree of cluster centres held in external
//   storage. One query point is accepted in IDLE. The tree is walked root to
//   leaf, recording every visited node on a small stack. The search then
//   backtracks and re-descends into a sibling subtree only when the splitting
//   plane is strictly closer than the best Manhattan distance found so far.
//   Nodes are read one per fetch over a read port with a latency of 1 cycle.
//   The tree is stored in heap layout: the children of node i are 2i+1 (left)
//   and 2i+2 (right).
//
// Parameters
//   dim        coordinates per centre; the split axis is level % dim
//   data_range largest coordinate value
//   depth      number of tree levels (2**depth-1 nodes)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset; a query in flight is aborted
//   pt_valid      query point offered
//   pt_ready      high only while idle
//   point         query; coordinate k is at [k*dim_size +: dim_size]
//   node_addr     tree read address (driven only while node_rd is high)
//   node_rd       read strobe; node_center is valid on the following cycle
//   node_center   centre stored at node_addr
//   res_valid     result presented and held until res_ready
//   res_ready     result consumer ready
//   best_center   nearest centre found
//   best_dist     Manhattan distance of best_center from the query
//   nodes_visited node evaluations in the current or last query
//
// Build option
//   KD_SEARCH_STATS_EN  when defined, nodes_visited counts node evaluations.
//                       It clears when a point is accepted and holds through
//                       the result. When not defined, nodes_visited is
//                       constant 0 and no counter is built.
// -----------------------------------------------------------------------------
module kd_nn_search #(
  parameter int dim        = 3,
  parameter int data_range = 255,
  parameter int depth      = 3,
  localparam int dim_size  = $clog2(data_range),
  localparam int dist_size = $clog2(data_range * dim),
  localparam int nodes     = 2**depth - 1,
  localparam int addr_w    = $clog2(nodes + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pt_valid,
  output logic                      pt_ready,
  input  logic [dim*dim_size-1:0]   point,
  output logic [addr_w-1:0]         node_addr,
  output logic                      node_rd,
  input  logic [dim*dim_size-1:0]   node_center,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [dim*dim_size-1:0]   best_center,
  output logic [dist_size-1:0]      best_dist,
  output logic [addr_w-1:0]         nodes_visited
);

  // Child indices need two spare bits so that 2*cur+2 never wraps past the
  // tree, even from the last leaf.
  localparam int idx_w = $clog2(nodes) + 2;
  // Level runs one past the last tree level when a descent falls off a leaf.
  localparam int lvl_w = $clog2(depth + 1);
  localparam int sp_w  = $clog2(depth + 1);
  localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [idx_w-1:0] nodes_idx = idx_w'(nodes);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EVAL,
    BACKTRACK,
    DONE
  } state_t;

  // One entry per tree level on the current path.
  typedef struct packed {
    logic [idx_w-1:0]    cur;      // node index
    logic [lvl_w-1:0]    level;    // tree level of that node
    logic                go_left;  // branch taken on the first descent
    logic                tried;    // sibling subtree already considered
    logic [dim_size-1:0] node_a;   // node coordinate on its split axis
  } entry_t;

  state_t                  state_q, state_d;
  logic [dim*dim_size-1:0] point_q;
  logic [idx_w-1:0]        cur_q;
  logic [lvl_w-1:0]        level_q;
  logic [sp_w-1:0]         sp_q;
  entry_t                  stack_mem [depth];
  logic [dim*dim_size-1:0] best_center_q;
  logic [dist_size-1:0]    best_dist_q;

  function automatic logic [dim_size-1:0] abs_diff(input logic [dim_size-1:0] a,
                                                   input logic [dim_size-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [dim_size-1:0] coord(input logic [dim*dim_size-1:0] v,
                                                input int k);
    return v[k*dim_size +: dim_size];
  endfunction

  function automatic int axis_of(input logic [lvl_w-1:0] lvl);
    return int'(lvl) % dim;
  endfunction

  // ---------------------------------------------------------------------------
  // Node evaluation (EVAL): distance to the fetched centre and descent branch.
  // ---------------------------------------------------------------------------
  logic [dist_size-1:0] eval_dist;
  logic                 eval_better;
  logic [dim_size-1:0]  eval_pt_a;
  logic [dim_size-1:0]  eval_node_a;
  logic                 eval_go_left;
  logic [idx_w-1:0]     eval_base;
  logic [idx_w-1:0]     next_idx;
  logic                 next_in_tree;

  always_comb begin
    // NOTE: blocking assignments are correct here; the accumulator is pure
    // combinational logic rebuilt on every evaluation, not stored state.
    eval_dist = '0;
    for (int k = 0; k < dim; k++) begin
      eval_dist = eval_dist + dist_size'(abs_diff(coord(point_q, k), coord(node_center, k)));
    end
  end

  // Strict compare: on a tie the centre found earlier stays best.
  assign eval_better  = eval_dist < best_dist_q;
  assign eval_pt_a    = coord(point_q, axis_of(level_q));
  assign eval_node_a  = coord(node_center, axis_of(level_q));
  // A point lying exactly on the split plane descends right.
  assign eval_go_left = eval_pt_a < eval_node_a;
  assign eval_base    = {cur_q[idx_w-2:0], 1'b0};
  assign next_idx     = eval_go_left ? eval_base + idx_w'(1) : eval_base + idx_w'(2);
  assign next_in_tree = next_idx < nodes_idx;

  // ---------------------------------------------------------------------------
  // Backtrack decision on the top stack entry.
  // ---------------------------------------------------------------------------
  logic                 stack_empty;
  logic [ptr_w-1:0]     top_ptr;
  entry_t               top;
  logic [dim_size-1:0]  top_pt_a;
  logic [dim_size-1:0]  plane_diff;
  logic                 bt_descend;
  logic [idx_w-1:0]     top_base;
  logic [idx_w-1:0]     other_idx;
  logic                 other_in_tree;

  assign stack_empty   = (sp_q == '0);
  assign top_ptr       = ptr_w'(sp_q - 1'b1);
  assign top           = stack_mem[top_ptr];
  assign top_pt_a      = coord(point_q, axis_of(top.level));
  assign plane_diff    = abs_diff(top_pt_a, top.node_a);
  // The sibling subtree can only hold a closer centre when the split plane
  // itself is strictly closer than the current best.
  assign bt_descend    = !top.tried && (dist_size'(plane_diff) < best_dist_q);
  assign top_base      = {top.cur[idx_w-2:0], 1'b0};
  assign other_idx     = top.go_left ? top_base + idx_w'(2) : top_base + idx_w'(1);
  assign other_in_tree = other_idx < nodes_idx;

  // ---------------------------------------------------------------------------
  // Control FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pt_ready  = 1'b0;
    node_rd   = 1'b0;
    node_addr = '0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        pt_ready = 1'b1;
        if (pt_valid) state_d = FETCH;
      end
      FETCH: begin
        node_rd   = 1'b1;
        node_addr = cur_q[addr_w-1:0];
        state_d   = EVAL;
      end
      EVAL: begin
        state_d = next_in_tree ? FETCH : BACKTRACK;
      end
      BACKTRACK: begin
        if (stack_empty)                     state_d = DONE;
        else if (bt_descend && other_in_tree) state_d = FETCH;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Search datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      point_q       <= '0;
      cur_q         <= '0;
      level_q       <= '0;
      sp_q          <= '0;
      best_center_q <= '0;
      best_dist_q   <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pt_valid) begin
            point_q       <= point;
            cur_q         <= '0;
            level_q       <= '0;
            sp_q          <= '0;
            best_center_q <= '0;
            best_dist_q   <= '1;
          end
        end
        EVAL: begin
          if (eval_better) begin
            best_center_q <= node_center;
            best_dist_q   <= eval_dist;
          end
          sp_q    <= sp_q + 1'b1;
          cur_q   <= next_idx;
          level_q <= level_q + 1'b1;
        end
        BACKTRACK: begin
          if (!stack_empty) begin
            if (bt_descend) begin
              if (other_in_tree) begin
                cur_q   <= other_idx;
                level_q <= top.level + 1'b1;
              end
            end else begin
              sp_q <= sp_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the stack storage has no reset; the stack pointer alone defines
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (state_q == EVAL) begin
      stack_mem[ptr_w'(sp_q)] <= '{cur:     cur_q,
                                   level:   level_q,
                                   go_left: eval_go_left,
                                   tried:   1'b0,
                                   node_a:  eval_node_a};
    end else if (state_q == BACKTRACK && !stack_empty && bt_descend) begin
      stack_mem[top_ptr].tried <= 1'b1;
    end
  end

  assign best_center = best_center_q;
  assign best_dist   = best_dist_q;

  // ---------------------------------------------------------------------------
  // Optional evaluation counter.
  // ---------------------------------------------------------------------------
`ifdef KD_SEARCH_STATS_EN
  logic [addr_w-1:0] visited_q;

  always_ff @(posedge clk) begin
    if (rst)                                visited_q <= '0;
    else if (state_q == IDLE && pt_valid)   visited_q <= '0;
    else if (state_q == EVAL)               visited_q <= visited_q + 1'b1;
  end

  assign nodes_visited = visited_q;
`else
  assign nodes_visited = '0;
`endif

endmodule

// File: tb/tb_kd_nn_search.sv
// -----------------------------------------------------------------------------
// tb_kd_nn_search
//   Bench for kd_nn_search with dim=3, data_range=255 and depth=2 (3 nodes).
//   The stimulus side pushes the expected result of every accepted query into
//   a scoreboard queue. A monitor pops the queue and compares whenever a result
//   handshake completes. Expected values come from fixed vectors for the
//   reference tree, and from a recursive-order nearest-neighbour reference
//   model for random trees and queries.
// -----------------------------------------------------------------------------
module tb_kd_nn_search;

  localparam int DIM       = 3;
  localparam int DR        = 255;
  localparam int DEPTH     = 2;
  localparam int NODES     = 3;
  localparam int DS        = 8;
  localparam int DW        = 10;
  localparam int AW        = 2;
  localparam int LAT_LIMIT = 4 * NODES + 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pt_valid = 1'b0;
  logic              pt_ready;
  logic [DIM*DS-1:0] point = '0;
  logic [AW-1:0]     node_addr;
  logic              node_rd;
  logic [DIM*DS-1:0] node_center = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [DIM*DS-1:0] best_center;
  logic [DW-1:0]     best_dist;
  logic [AW-1:0]     nodes_visited;

  kd_nn_search #(.dim(DIM), .data_range(DR), .depth(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pt_valid      (pt_valid),
    .pt_ready      (pt_ready),
    .point         (point),
    .node_addr     (node_addr),
    .node_rd       (node_rd),
    .node_center   (node_center),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .best_center   (best_center),
    .best_dist     (best_dist),
    .nodes_visited (nodes_visited)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DIM*DS-1:0] c;
    logic [DW-1:0]     d;
    logic [AW-1:0]     v;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [7:0]  tree [NODES][DIM];
  int          bp_mode = 0;   // 0: always ready, 1: random, 2: held low
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [DIM*DS-1:0] pack3(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic int coord(input logic [DIM*DS-1:0] p, input int k);
    return int'(p[k*DS +: DS]);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [AW-1:0] exp_visits(input int v);
`ifdef KD_SEARCH_STATS_EN
    return AW'(v);
`else
    return AW'(0);
`endif
  endfunction

  function automatic exp_t mk(input logic [DIM*DS-1:0] c, input int d, input int v);
    exp_t e;
    e.c = c;
    e.d = DW'(d);
    e.v = exp_visits(v);
    return e;
  endfunction

  // Nearest-neighbour search in recursive order: visit a node, search the
  // near subtree, then the far subtree if the split plane is strictly closer
  // than the best so far. Frames: node, level, phase (0 visit, 1 far, 2 done).
  function automatic exp_t model(input logic [DIM*DS-1:0] p);
    exp_t e;
    int   fn[$];
    int   fl[$];
    int   fp[$];
    int   best, vis, top, n, lvl, ax, d, pa, na;
    best = (1 << DW) - 1;
    vis  = 0;
    e.c  = '0;
    fn.push_back(0); fl.push_back(0); fp.push_back(0);
    while (fn.size() > 0) begin
      top = fn.size() - 1;
      n   = fn[top];
      lvl = fl[top];
      ax  = lvl % DIM;
      if (n >= NODES || fp[top] == 2) begin
        void'(fn.pop_back()); void'(fl.pop_back()); void'(fp.pop_back());
      end else begin
        pa = coord(p, ax);
        na = int'(tree[n][ax]);
        if (fp[top] == 0) begin
          d = 0;
          for (int k = 0; k < DIM; k++) d += iabs(coord(p, k) - int'(tree[n][k]));
          vis++;
          if (d < best) begin
            best = d;
            e.c  = pack3(int'(tree[n][0]), int'(tree[n][1]), int'(tree[n][2]));
          end
          fp[top] = 1;
          fn.push_back((pa < na) ? 2*n + 1 : 2*n + 2);
          fl.push_back(lvl + 1); fp.push_back(0);
        end else begin
          fp[top] = 2;
          if (iabs(pa - na) < best) begin
            fn.push_back((pa < na) ? 2*n + 2 : 2*n + 1);
            fl.push_back(lvl + 1); fp.push_back(0);
          end
        end
      end
    end
    e.d = DW'(best);
    e.v = exp_visits(vis);
    return e;
  endfunction

  // Tree storage: one-cycle read latency.
  always @(posedge clk) begin
    if (node_rd)
      node_center <= pack3(int'(tree[node_addr][0]), int'(tree[node_addr][1]),
                           int'(tree[node_addr][2]));
  end

  // Result consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every completed result against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      wait_cnt = 0;
    end else begin
      if (node_rd) check("node_addr_range", 32'(node_addr < AW'(NODES)), 32'd1);
      if (res_valid) begin
        wait_cnt = 0;
        check("pt_ready_in_done", 32'(pt_ready), 32'd0);
        if (res_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("best_center", 32'(best_center), 32'(e.c));
            check("best_dist", 32'(best_dist), 32'(e.d));
            check("nodes_visited", 32'(nodes_visited), 32'(e.v));
          end
        end
      end else if (sb.size() != 0) begin
        wait_cnt++;
        if (wait_cnt > LAT_LIMIT) begin
          check("result_latency", 32'(wait_cnt), 32'(LAT_LIMIT));
          wait_cnt = 0;
        end
      end
    end
  end

  task automatic send(input logic [DIM*DS-1:0] p, input exp_t e);
    int n = 0;
    @(negedge clk);
    point    = p;
    pt_valid = 1'b1;
    while (!pt_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!pt_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      pt_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !pt_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !pt_ready) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_reference_tree();
    tree[0][0] = 8'd100; tree[0][1] = 8'd50; tree[0][2] = 8'd50;
    tree[1][0] = 8'd40;  tree[1][1] = 8'd10; tree[1][2] = 8'd10;
    tree[2][0] = 8'd200; tree[2][1] = 8'd90; tree[2][2] = 8'd90;
  endtask

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [DIM*DS-1:0] held_c;
    logic [DW-1:0]     held_d;
    logic [DIM*DS-1:0] p;
    int                rng;
    int                n;

    load_reference_tree();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pt_ready", 32'(pt_ready), 32'd1);
    check("rst_node_rd", 32'(node_rd), 32'd0);
    check("rst_node_addr", 32'(node_addr), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_best_center", 32'(best_center), 32'd0);
    check("rst_best_dist", 32'(best_dist), 32'd1023);
    check("rst_nodes_visited", 32'(nodes_visited), 32'd0);
    rst = 1'b0;

    // Reference-tree vectors.
    send(pack3(45, 12, 12),   mk(pack3(40, 10, 10), 9, 2));    drain();
    send(pack3(150, 50, 50),  mk(pack3(100, 50, 50), 50, 2));  drain();
    send(pack3(100, 0, 0),    mk(pack3(40, 10, 10), 80, 3));   drain();
    send(pack3(70, 30, 30),   mk(pack3(100, 50, 50), 70, 3));  drain();

    // Reset while evaluating: no result, fresh query afterwards.
    @(negedge clk);
    point    = pack3(45, 12, 12);
    pt_valid = 1'b1;
    @(negedge clk);
    pt_valid = 1'b0;
    check("abort_fetch_strobe", 32'(node_rd), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_pt_ready", 32'(pt_ready), 32'd1);
    rst = 1'b0;
    send(pack3(100, 0, 0), mk(pack3(40, 10, 10), 80, 3));
    drain();

    // Result held under back-pressure; a new point offered meanwhile is ignored.
    bp_mode = 2;
    send(pack3(150, 50, 50), mk(pack3(100, 50, 50), 50, 2));
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_result_arrives", 32'(res_valid), 32'd1);
    held_c   = best_center;
    held_d   = best_dist;
    point    = pack3(1, 2, 3);
    pt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_best_center", 32'(best_center), 32'(held_c));
      check("stall_best_dist", 32'(best_dist), 32'(held_d));
      check("stall_pt_ready", 32'(pt_ready), 32'd0);
    end
    pt_valid = 1'b0;
    bp_mode  = 0;
    drain();

    // Random trees and queries; small ranges provoke ties and plane equality.
    for (int b = 0; b < 40; b++) begin
      rng = (b % 2 == 0) ? 15 : 255;
      for (int i = 0; i < NODES; i++)
        for (int k = 0; k < DIM; k++)
          tree[i][k] = 8'($urandom_range(0, rng));
      bp_mode = 1;
      for (int q = 0; q < 8; q++) begin
        p = pack3($urandom_range(0, rng), $urandom_range(0, rng), $urandom_range(0, rng));
        send(p, model(p));
      end
      drain();
    end
    bp_mode = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
